grf_hazard_ctrl: RTL and testbench

- Hazard and scoreboard controller for the 5-stage pipeline's general register file.
- Tracks in-flight GRF writers in the E, M and W stages and produces the D-stage stall.
- Produces per-operand forwarding selects for the rs/rt read ports.
- Sequences the multiply/divide unit's busy window so HI/LO accesses stall correctly.

---
 rtl/grf_hazard_ctrl_pkg.sv | 31 +++
 rtl/grf_hazard_ctrl_md_busy_timer.sv | 36 +++
 rtl/grf_hazard_ctrl.sv | 121 ++++++++++++
 tb/tb_grf_hazard_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/grf_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : grf_hz_pkg
//  Description : Shared encodings, pipeline slot type and helpers for the
//                GRF hazard / scoreboard controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package grf_hz_pkg;

    // Forwarding select encodings for the D-stage rs/rt read ports
    localparam logic [1:0] FWD_GRF   = 2'd0;
    localparam logic [1:0] FWD_M     = 2'd1;
    localparam logic [1:0] FWD_E     = 2'd2;

    // Operand is not read by the instruction at all
    localparam logic [1:0] TUSE_NONE = 2'd3;

    // One in-flight GRF writer
    typedef struct packed {
        logic       valid;
        logic [4:0] dst;
        logic [1:0] tnew_rem;
    } grf_slot_t;

    // Remaining-latency countdown that stops at zero
    function automatic logic [1:0] sat_dec(input logic [1:0] v);
        return (v == 2'd0) ? 2'd0 : v - 2'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/grf_hazard_ctrl_md_busy_timer.sv
`default_nettype none
// ============================================================================
//  Module      : md_busy_timer
//  Description : Busy-window counter for the multiply/divide unit. Loads the
//                operation latency on issue and counts down to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module md_busy_timer #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10,
    parameter int CNT_W    = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic load_div,
    output logic busy
);

    logic [CNT_W-1:0] md_cnt;

    // Load on an accepted md start, otherwise count down and hold at zero
    always_ff @(posedge clk) begin
        if (reset) begin
            md_cnt <= '0;
        end else if (load) begin
            md_cnt <= load_div ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
        end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - CNT_W'(1);
        end
    end

    assign busy = (md_cnt != '0);

endmodule
`default_nettype wire

// File: rtl/grf_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : grf_hazard_ctrl
//  Description : GRF scoreboard for the 5-stage pipeline. Tracks E/M/W
//                writers, generates the D-stage stall and the rs/rt
//                forwarding selects, and gates HI/LO access on md busy.
//  Revision    : 1.0 - initial release
// ============================================================================
module grf_hazard_ctrl
    import grf_hz_pkg::*;
#(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10,
    parameter int CNT_W    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [1:0]  id_tuse_rs,
    input  logic [1:0]  id_tuse_rt,
    input  logic [4:0]  id_dst,
    input  logic [1:0]  id_tnew,
    input  logic        id_md_start,
    input  logic        id_md_div,
    input  logic        id_md_use,
    output logic        stall,
    output logic [1:0]  fwd_rs_sel,
    output logic [1:0]  fwd_rt_sel,
    output logic        md_busy,
    output logic [31:0] pend_mask
);

    grf_slot_t slot_e;
    grf_slot_t slot_m;
    grf_slot_t slot_w;
    grf_slot_t issue_slot;

    logic rs_stall;
    logic rt_stall;
    logic md_stall;
    logic issue;

    // Data hazard for one source: the youngest matching writer decides
    function automatic logic src_stall(input logic [4:0] s, input logic [1:0] tuse,
                                       input grf_slot_t e, input grf_slot_t m,
                                       input grf_slot_t w);
        if (s == 5'd0 || tuse == TUSE_NONE) return 1'b0;
        if (e.valid && e.dst == s) return (e.tnew_rem > tuse);
        if (m.valid && m.dst == s) return (m.tnew_rem > tuse);
        if (w.valid && w.dst == s) return (w.tnew_rem > tuse);
        return 1'b0;
    endfunction

    // Forward select for one source; a not-yet-ready youngest writer
    // shadows any older ready one, so the value falls back to the GRF
    function automatic logic [1:0] src_sel(input logic [4:0] s,
                                           input grf_slot_t e, input grf_slot_t m);
        if (s == 5'd0) return FWD_GRF;
        if (e.valid && e.dst == s) return (e.tnew_rem == 2'd0) ? FWD_E : FWD_GRF;
        if (m.valid && m.dst == s) return (m.tnew_rem == 2'd0) ? FWD_M : FWD_GRF;
        return FWD_GRF;
    endfunction

    // D-stage hazard evaluation, purely from slot state and D inputs
    always_comb begin
        issue_slot.valid    = (id_dst != 5'd0);
        issue_slot.dst      = id_dst;
        issue_slot.tnew_rem = id_tnew;

        rs_stall   = src_stall(id_rs, id_tuse_rs, slot_e, slot_m, slot_w);
        rt_stall   = src_stall(id_rt, id_tuse_rt, slot_e, slot_m, slot_w);
        md_stall   = id_md_use && md_busy;
        stall      = id_valid && (rs_stall || rt_stall || md_stall);
        issue      = id_valid && !stall;

        fwd_rs_sel = src_sel(id_rs, slot_e, slot_m);
        fwd_rt_sel = src_sel(id_rt, slot_e, slot_m);
    end

    // Advance the E -> M -> W writer pipeline; a stall injects a bubble
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_e <= '0;
            slot_m <= '0;
            slot_w <= '0;
        end else begin
            slot_w          <= slot_m;
            slot_w.tnew_rem <= sat_dec(slot_m.tnew_rem);
            slot_m          <= slot_e;
            slot_m.tnew_rem <= sat_dec(slot_e.tnew_rem);
            slot_e          <= issue ? issue_slot : '0;
        end
    end

    // Pending-writer mask; $0 is never a real destination
    for (genvar r = 0; r < 32; r++) begin : g_pend
        if (r == 0) begin : g_zero
            assign pend_mask[r] = 1'b0;
        end else begin : g_reg
            assign pend_mask[r] = (slot_e.valid && slot_e.dst == 5'(r)) ||
                                  (slot_m.valid && slot_m.dst == 5'(r)) ||
                                  (slot_w.valid && slot_w.dst == 5'(r));
        end
    end

    md_busy_timer #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC),
        .CNT_W    (CNT_W)
    ) u_md_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (issue && id_md_start),
        .load_div (id_md_div),
        .busy     (md_busy)
    );

endmodule
`default_nettype wire

// File: tb/tb_grf_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_grf_hazard_ctrl
//  Description : Directed vector bench for grf_hazard_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_grf_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_dst;
    logic [1:0]  id_tuse_rs, id_tuse_rt, id_tnew;
    logic        id_md_start, id_md_div, id_md_use;
    logic        stall, md_busy;
    logic [1:0]  fwd_rs_sel, fwd_rt_sel;
    logic [31:0] pend_mask;

    grf_hazard_ctrl #(.MULT_CYC(5), .DIV_CYC(10), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_tuse_rs(id_tuse_rs), .id_tuse_rt(id_tuse_rt),
        .id_dst(id_dst), .id_tnew(id_tnew), .id_md_start(id_md_start),
        .id_md_div(id_md_div), .id_md_use(id_md_use), .stall(stall),
        .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel), .md_busy(md_busy),
        .pend_mask(pend_mask)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [4:0]  rs;
        logic [1:0]  tuse_rs;
        logic [4:0]  rt;
        logic [1:0]  tuse_rt;
        logic [4:0]  dst;
        logic [1:0]  tnew;
        logic        md_start, md_div, md_use;
        logic        e_stall;
        logic [1:0]  e_rs_sel, e_rt_sel;
        logic        chk_sel;
        logic        e_busy;
        logic [31:0] e_pend;
    } vec_t;

    int   n_vec = 0;
    int   n_err = 0;
    vec_t tbl[20];
    vec_t idle_v, v;

    function automatic vec_t mk(input logic va, input logic [4:0] rs, input logic [1:0] tr,
                                input logic [4:0] rt, input logic [1:0] tt,
                                input logic [4:0] dst, input logic [1:0] tn,
                                input logic ms, input logic md, input logic mu,
                                input logic es, input logic [1:0] ers, input logic [1:0] ert,
                                input logic cs, input logic eb, input logic [31:0] ep);
        vec_t r;
        r.valid = va; r.rs = rs; r.tuse_rs = tr; r.rt = rt; r.tuse_rt = tt;
        r.dst = dst; r.tnew = tn; r.md_start = ms; r.md_div = md; r.md_use = mu;
        r.e_stall = es; r.e_rs_sel = ers; r.e_rt_sel = ert; r.chk_sel = cs;
        r.e_busy = eb; r.e_pend = ep;
        return r;
    endfunction

    task automatic drive(input vec_t x);
        id_valid = x.valid; id_rs = x.rs; id_tuse_rs = x.tuse_rs;
        id_rt = x.rt; id_tuse_rt = x.tuse_rt; id_dst = x.dst; id_tnew = x.tnew;
        id_md_start = x.md_start; id_md_div = x.md_div; id_md_use = x.md_use;
    endtask

    task automatic check(input string tag, input vec_t x);
        n_vec++;
        if (stall !== x.e_stall) begin
            n_err++; $display("FAIL %s stall: got %0b want %0b", tag, stall, x.e_stall);
        end
        if (md_busy !== x.e_busy) begin
            n_err++; $display("FAIL %s md_busy: got %0b want %0b", tag, md_busy, x.e_busy);
        end
        if (pend_mask !== x.e_pend) begin
            n_err++; $display("FAIL %s pend_mask: got %h want %h", tag, pend_mask, x.e_pend);
        end
        if (x.chk_sel && !x.e_stall) begin
            if (fwd_rs_sel !== x.e_rs_sel) begin
                n_err++; $display("FAIL %s fwd_rs_sel: got %0d want %0d", tag, fwd_rs_sel, x.e_rs_sel);
            end
            if (fwd_rt_sel !== x.e_rt_sel) begin
                n_err++; $display("FAIL %s fwd_rt_sel: got %0d want %0d", tag, fwd_rt_sel, x.e_rt_sel);
            end
        end
    endtask

    // Present x for one cycle, compare mid-cycle, then take the edge
    task automatic step(input string tag, input vec_t x);
        drive(x);
        @(negedge clk);
        check(tag, x);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(idle_v);
            @(posedge clk);
            #1;
        end
    endtask

    // md op followed by an HI/LO reader presented immediately
    task automatic md_seq(input string tag, input logic is_div, input int ncyc);
        step({tag, "_start"}, mk(1, 0,3, 0,3, 0,0, 1,is_div,1, 0,0,0,1,0, 32'h0));
        for (int k = 0; k < ncyc; k++)
            step($sformatf("%s_wait%0d", tag, k), mk(1, 0,3, 0,3, 10,1, 0,0,1, 1,0,0,0,1, 32'h0));
        step({tag, "_go"}, mk(1, 0,3, 0,3, 10,1, 0,0,1, 0,0,0,1,0, 32'h0));
        idle(3);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running want done");
        $fatal(1);
    end

    initial begin
        idle_v = mk(0, 0,3, 0,3, 0,0, 0,0,0, 0,0,0,1,0, 32'h0);

        // valid rs tr rt tt dst tn ms md mu | stall rs rt chk busy pend
        tbl[0]  = mk(0,  0,3,  0,3, 0,0, 0,0,0, 0,0,0,1,0, 32'h0);
        tbl[1]  = mk(1, 10,1, 11,1, 1,1, 0,0,0, 0,0,0,1,0, 32'h0);     // add $1
        tbl[2]  = mk(1,  1,1,  0,1, 2,1, 0,0,0, 0,0,0,1,0, 32'h2);     // add $2,$1
        tbl[3]  = mk(1,  1,1,  2,1, 6,1, 0,0,0, 0,1,0,1,0, 32'h6);     // $1 from M
        tbl[4]  = mk(1,  1,1,  0,3, 3,2, 0,0,0, 0,0,0,1,0, 32'h46);    // lw $3
        tbl[5]  = mk(1,  3,0,  6,0, 0,0, 0,0,0, 1,0,0,0,0, 32'h4C);    // beq $3 stall
        tbl[6]  = mk(1,  3,0,  6,0, 0,0, 0,0,0, 1,0,0,0,0, 32'h48);    // stall 2
        tbl[7]  = mk(1,  3,0,  6,0, 0,0, 0,0,0, 0,0,0,0,0, 32'h08);    // released
        tbl[8]  = mk(1,  0,3,  0,3, 3,2, 0,0,0, 0,0,0,1,0, 32'h0);     // lw $3
        tbl[9]  = mk(1,  3,1,  0,3, 7,1, 0,0,0, 1,0,0,0,0, 32'h08);    // add: 1 stall
        tbl[10] = mk(1,  3,1,  0,3, 7,1, 0,0,0, 0,0,0,0,0, 32'h08);
        tbl[11] = mk(1,  0,3,  0,3, 4,0, 0,0,0, 0,0,0,1,0, 32'h88);    // lui $4
        tbl[12] = mk(1,  4,0,  7,0, 0,0, 0,0,0, 0,2,1,1,0, 32'h90);    // beq $4,$7
        tbl[13] = mk(1,  0,3,  0,3, 5,1, 0,0,0, 0,0,0,1,0, 32'h90);    // ori $5
        tbl[14] = mk(1,  0,3,  0,3, 5,0, 0,0,0, 0,0,0,1,0, 32'h30);    // lui $5
        tbl[15] = mk(1,  5,1,  5,1, 8,1, 0,0,0, 0,2,2,1,0, 32'h20);    // younger wins
        tbl[16] = mk(1,  0,3,  0,3, 0,1, 0,0,0, 0,0,0,1,0, 32'h120);   // write $0
        tbl[17] = mk(1,  0,0,  8,0, 9,1, 0,0,0, 0,0,1,1,0, 32'h120);   // read $0
        tbl[18] = mk(0,  9,0,  0,3, 0,0, 0,0,0, 0,0,0,0,0, 32'h300);   // invalid D
        tbl[19] = mk(0,  0,3,  0,3, 0,0, 0,0,0, 0,0,0,1,0, 32'h200);

        reset = 1'b1;
        drive(idle_v);
        @(posedge clk); @(posedge clk); #1;
        step("reset_state", mk(1, 3,0, 3,0, 0,0, 0,0,1, 0,0,0,1,0, 32'h0));
        reset = 1'b0;

        for (int i = 0; i < 20; i++)
            step($sformatf("vec%0d", i), tbl[i]);

        idle(3);
        md_seq("div_mflo", 1'b1, 10);
        md_seq("mult_mfhi", 1'b0, 5);

        // div, ten non-md instructions run alongside, then mflo is free
        step("div11_start", mk(1, 0,3, 0,3, 0,0, 1,1,1, 0,0,0,1,0, 32'h0));
        for (int k = 0; k < 10; k++)
            step($sformatf("div11_alu%0d", k), mk(1, 0,3, 0,3, 0,1, 0,0,0, 0,0,0,1,1, 32'h0));
        step("div11_mflo", mk(1, 0,3, 0,3, 0,1, 0,0,1, 0,0,0,1,0, 32'h0));
        idle(3);

        // reset while a lw is in E and the md counter sits at 7
        step("rst_div", mk(1, 0,3, 0,3, 0,0, 1,1,1, 0,0,0,1,0, 32'h0));
        step("rst_n1",  mk(0, 0,3, 0,3, 0,0, 0,0,0, 0,0,0,1,1, 32'h0));
        step("rst_n2",  mk(0, 0,3, 0,3, 0,0, 0,0,0, 0,0,0,1,1, 32'h0));
        step("rst_lw",  mk(1, 0,3, 0,3, 3,2, 0,0,0, 0,0,0,1,1, 32'h0));
        v = mk(1, 3,0, 0,3, 0,0, 0,0,1, 1,0,0,0,1, 32'h08);
        reset = 1'b1;
        step("rst_pre", v);
        reset = 1'b0;
        step("rst_post", mk(1, 3,0, 0,3, 0,0, 0,0,1, 0,0,0,1,0, 32'h0));
        step("rst_post2", mk(1, 3,0, 3,0, 0,0, 0,0,1, 0,0,0,1,0, 32'h0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
